// File: rtl/bp_c_mult1.sv
// First nonlinear layer of the masked Boyar-Peralta S-box: nine HPC2 ANDs plus
// the share-wise XOR fold into M20..M23. One cycle latency, free-running, no backpressure.

module MSKand_hpc2 #(
  parameter int d = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [d-1:0]           ina_i,
  input  logic [d-1:0]           inb_i,
  input  logic [d*(d-1)/2-1:0]   rnd_i,
  output logic [d-1:0]           out_o
);
  localparam int R = d*(d-1)/2;

  // Index of the random bit shared by share pair (i, j), i < j.
  function automatic int pidx(input int i, input int j);
    return i*d - (i*(i+1))/2 + (j-i-1);
  endfunction

  logic [d-1:0]          a_q;
  logic [d-1:0][d-1:0]   bm_d, bm_q;
  logic [R-1:0]          r_q;

  // Diagonal carries b_i; off-diagonal carries b_j blinded by r_ij before any AND.
  always_comb begin
    bm_d = '0;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        if (i == j)
          bm_d[i][j] = inb_i[j];
        else if (i < j)
          bm_d[i][j] = inb_i[j] ^ rnd_i[pidx(i, j)];
        else
          bm_d[i][j] = inb_i[j] ^ rnd_i[pidx(j, i)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      bm_q <= '0;
      r_q  <= '0;
    end else begin
      a_q  <= ina_i;
      bm_q <= bm_d;
      r_q  <= rnd_i;
    end
  end

  always_comb begin
    out_o = '0;
    for (int i = 0; i < d; i++) begin
      out_o[i] = a_q[i] & bm_q[i][i];
      for (int j = 0; j < d; j++) begin
        if (j != i)
          out_o[i] = out_o[i] ^ (a_q[i] & bm_q[i][j])
                     ^ (~a_q[i] & r_q[(i < j) ? pidx(i, j) : pidx(j, i)]);
      end
    end
  end
endmodule

module bp_c_mult1 #(
  parameter int d = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [d-1:0]                 i0,
  input  logic [d-1:0]                 t1,
  input  logic [d-1:0]                 t2,
  input  logic [d-1:0]                 t3,
  input  logic [d-1:0]                 t4,
  input  logic [d-1:0]                 t6,
  input  logic [d-1:0]                 t8,
  input  logic [d-1:0]                 t9,
  input  logic [d-1:0]                 t10,
  input  logic [d-1:0]                 t13,
  input  logic [d-1:0]                 t14,
  input  logic [d-1:0]                 t15,
  input  logic [d-1:0]                 t16,
  input  logic [d-1:0]                 t17,
  input  logic [d-1:0]                 t19,
  input  logic [d-1:0]                 t20,
  input  logic [d-1:0]                 t22,
  input  logic [d-1:0]                 t23,
  input  logic [d-1:0]                 t24,
  input  logic [d-1:0]                 t25,
  input  logic [d-1:0]                 t26,
  input  logic [d-1:0]                 t27,
  input  logic [9*(d*(d-1)/2)-1:0]     rnd,
  output logic                         out_valid,
  output logic [d-1:0]                 m20,
  output logic [d-1:0]                 m21,
  output logic [d-1:0]                 m22,
  output logic [d-1:0]                 m23
);
  localparam int R = d*(d-1)/2;

  logic [d-1:0] m1, m2, m4, m6, m7, m9, m11, m12, m14;
  logic [d-1:0] m3, m5, m8, m10, m13, m15, m16, m17, m18, m19;
  logic [d-1:0] t14_q, t24_q, t25_q, t26_q;
  logic         valid_q;

  MSKand_hpc2 #(.d(d)) u_m1  (.clk(clk), .rst(rst), .ina_i(t13), .inb_i(t6),  .rnd_i(rnd[0*R +: R]), .out_o(m1));
  MSKand_hpc2 #(.d(d)) u_m2  (.clk(clk), .rst(rst), .ina_i(t23), .inb_i(t8),  .rnd_i(rnd[1*R +: R]), .out_o(m2));
  MSKand_hpc2 #(.d(d)) u_m4  (.clk(clk), .rst(rst), .ina_i(t19), .inb_i(i0),  .rnd_i(rnd[2*R +: R]), .out_o(m4));
  MSKand_hpc2 #(.d(d)) u_m6  (.clk(clk), .rst(rst), .ina_i(t3),  .inb_i(t16), .rnd_i(rnd[3*R +: R]), .out_o(m6));
  MSKand_hpc2 #(.d(d)) u_m7  (.clk(clk), .rst(rst), .ina_i(t22), .inb_i(t9),  .rnd_i(rnd[4*R +: R]), .out_o(m7));
  MSKand_hpc2 #(.d(d)) u_m9  (.clk(clk), .rst(rst), .ina_i(t20), .inb_i(t17), .rnd_i(rnd[5*R +: R]), .out_o(m9));
  MSKand_hpc2 #(.d(d)) u_m11 (.clk(clk), .rst(rst), .ina_i(t1),  .inb_i(t15), .rnd_i(rnd[6*R +: R]), .out_o(m11));
  MSKand_hpc2 #(.d(d)) u_m12 (.clk(clk), .rst(rst), .ina_i(t4),  .inb_i(t27), .rnd_i(rnd[7*R +: R]), .out_o(m12));
  MSKand_hpc2 #(.d(d)) u_m14 (.clk(clk), .rst(rst), .ina_i(t2),  .inb_i(t10), .rnd_i(rnd[8*R +: R]), .out_o(m14));

  // Linear-only operands ride alongside the gadgets so the fold sees one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t14_q   <= '0;
      t24_q   <= '0;
      t25_q   <= '0;
      t26_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      t14_q   <= t14;
      t24_q   <= t24;
      t25_q   <= t25;
      t26_q   <= t26;
      valid_q <= in_valid;
    end
  end

  always_comb begin
    m3  = t14_q ^ m1;
    m5  = m4 ^ m1;
    m8  = t26_q ^ m6;
    m10 = m9 ^ m6;
    m13 = m12 ^ m11;
    m15 = m14 ^ m11;
    m16 = m3 ^ m2;
    m17 = m5 ^ t24_q;
    m18 = m8 ^ m7;
    m19 = m10 ^ m15;
  end

  assign m20       = m16 ^ m13;
  assign m21       = m17 ^ m15;
  assign m22       = m18 ^ m13;
  assign m23       = m19 ^ t25_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_bp_c_mult1.sv
// Directed bench for bp_c_mult1 with d=2: reset, hand vectors, streamed bytes, mid-stream reset.
module tb_bp_c_mult1;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] i0, t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15, t16, t17;
  logic [1:0] t19, t20, t22, t23, t24, t25, t26, t27;
  logic [8:0] rnd;
  logic       out_valid;
  logic [1:0] m20, m21, m22, m23;
  logic [3:0] um;
  logic [7:0] raw;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign um  = {^m20, ^m21, ^m22, ^m23};
  assign raw = {m20, m21, m22, m23};

  bp_c_mult1 #(.d(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .i0(i0),
    .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t6(t6), .t8(t8), .t9(t9), .t10(t10),
    .t13(t13), .t14(t14), .t15(t15), .t16(t16), .t17(t17), .t19(t19), .t20(t20),
    .t22(t22), .t23(t23), .t24(t24), .t25(t25), .t26(t26), .t27(t27),
    .rnd(rnd), .out_valid(out_valid),
    .m20(m20), .m21(m21), .m22(m22), .m23(m23)
  );

  // Boyar-Peralta top linear layer; bit 0 holds D (= U7), bit k holds Tk.
  function automatic logic [28:0] fwd(input logic [7:0] x);
    logic [0:7]  u;
    logic [28:0] t;
    u = x;
    t = '0;
    t[0]  = u[7];
    t[1]  = u[0] ^ u[3];
    t[2]  = u[0] ^ u[5];
    t[3]  = u[0] ^ u[6];
    t[4]  = u[3] ^ u[5];
    t[5]  = u[4] ^ u[6];
    t[6]  = t[1] ^ t[5];
    t[7]  = u[1] ^ u[2];
    t[8]  = u[7] ^ t[6];
    t[9]  = u[7] ^ t[7];
    t[10] = t[6] ^ t[7];
    t[11] = u[1] ^ u[5];
    t[12] = u[2] ^ u[5];
    t[13] = t[3] ^ t[4];
    t[14] = t[6] ^ t[11];
    t[15] = t[5] ^ t[11];
    t[16] = t[5] ^ t[12];
    t[17] = t[9] ^ t[16];
    t[18] = u[3] ^ u[7];
    t[19] = t[7] ^ t[18];
    t[20] = t[1] ^ t[19];
    t[21] = u[6] ^ u[7];
    t[22] = t[7] ^ t[21];
    t[23] = t[2] ^ t[22];
    t[24] = t[2] ^ t[10];
    t[25] = t[20] ^ t[17];
    t[26] = t[3] ^ t[16];
    t[27] = t[1] ^ t[12];
    return t;
  endfunction

  // Unmasked reference {M20, M21, M22, M23}.
  function automatic logic [3:0] ref_m(input logic [28:0] t);
    logic mm1, mm2, mm4, mm6, mm7, mm9, mm11, mm12, mm14;
    logic mm3, mm5, mm8, mm10, mm13, mm15, mm16, mm17, mm18, mm19;
    mm1  = t[13] & t[6];
    mm2  = t[23] & t[8];
    mm4  = t[19] & t[0];
    mm6  = t[3]  & t[16];
    mm7  = t[22] & t[9];
    mm9  = t[20] & t[17];
    mm11 = t[1]  & t[15];
    mm12 = t[4]  & t[27];
    mm14 = t[2]  & t[10];
    mm3  = t[14] ^ mm1;
    mm5  = mm4 ^ mm1;
    mm8  = t[26] ^ mm6;
    mm10 = mm9 ^ mm6;
    mm13 = mm12 ^ mm11;
    mm15 = mm14 ^ mm11;
    mm16 = mm3 ^ mm2;
    mm17 = mm5 ^ t[24];
    mm18 = mm8 ^ mm7;
    mm19 = mm10 ^ mm15;
    return {mm16 ^ mm13, mm17 ^ mm15, mm18 ^ mm13, mm19 ^ t[25]};
  endfunction

  function automatic logic [1:0] split(input logic b);
    logic r;
    r = 1'($urandom_range(1));
    return {r ^ b, r};
  endfunction

  // Drive one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic step(input logic [28:0] tv, input logic vld);
    @(negedge clk);
    in_valid = vld;
    i0  = split(tv[0]);  t1  = split(tv[1]);  t2  = split(tv[2]);
    t3  = split(tv[3]);  t4  = split(tv[4]);  t6  = split(tv[6]);
    t8  = split(tv[8]);  t9  = split(tv[9]);  t10 = split(tv[10]);
    t13 = split(tv[13]); t14 = split(tv[14]); t15 = split(tv[15]);
    t16 = split(tv[16]); t17 = split(tv[17]); t19 = split(tv[19]);
    t20 = split(tv[20]); t22 = split(tv[22]); t23 = split(tv[23]);
    t24 = split(tv[24]); t25 = split(tv[25]); t26 = split(tv[26]);
    t27 = split(tv[27]);
    rnd = 9'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    total++;
    if ({out_valid, raw} !== 9'h000) begin
      bad++;
      $display("FAIL reset_initial: got valid=%b m=%h want valid=0 m=00", out_valid, raw);
    end
    for (int i = 0; i < 4; i++) begin
      step(fwd(8'($urandom)), 1'(i % 2));
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_valid cyc%0d: got %b want 0", i, out_valid);
      end
      total++;
      if (raw !== 8'h00) begin
        bad++;
        $display("FAIL reset_data cyc%0d: got %h want 00", i, raw);
      end
    end
    rst = 1'b0;
    step(fwd(8'h53), 1'b1);
    total++;
    if ({out_valid, um} !== {1'b1, ref_m(fwd(8'h53))}) begin
      bad++;
      $display("FAIL first_after_reset: got valid=%b m=%b want valid=1 m=%b",
               out_valid, um, ref_m(fwd(8'h53)));
    end
    step(fwd(8'h00), 1'b0);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL valid_drop: got %b want 0", out_valid);
    end
  endtask

  task automatic test_directed();
    logic [28:0] vec [9];
    logic [3:0]  exp [9];
    vec[0] = 29'h0000000; exp[0] = 4'b0000;  // byte 0x00
    vec[1] = 29'h0DA0301; exp[1] = 4'b1111;  // byte 0x01
    vec[2] = 29'h0004000; exp[2] = 4'b1000;  // t14
    vec[3] = 29'h1000000; exp[3] = 4'b0100;  // t24
    vec[4] = 29'h4000000; exp[4] = 4'b0010;  // t26
    vec[5] = 29'h2000000; exp[5] = 4'b0001;  // t25
    vec[6] = 29'h0002040; exp[6] = 4'b1100;  // t13 & t6
    vec[7] = 29'h0008002; exp[7] = 4'b1111;  // t1 & t15
    vec[8] = 29'h0002000; exp[8] = 4'b0000;  // t13 alone
    for (int i = 0; i < 9; i++) begin
      step(vec[i], 1'b1);
      total++;
      if ({out_valid, um} !== {1'b1, exp[i]}) begin
        bad++;
        $display("FAIL directed%0d: got valid=%b m=%b want valid=1 m=%b", i, out_valid, um, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 256; b++) begin
      step(fwd(8'(b)), 1'b1);
      total++;
      if ({out_valid, um} !== {1'b1, ref_m(fwd(8'(b)))}) begin
        bad++;
        $display("FAIL stream byte %02h: got valid=%b m=%b want valid=1 m=%b",
                 b, out_valid, um, ref_m(fwd(8'(b))));
      end
    end
  endtask

  task automatic test_valid_toggle();
    logic [7:0] x;
    logic       v;
    for (int i = 0; i < 64; i++) begin
      x = 8'($urandom);
      v = 1'($urandom_range(1));
      step(fwd(x), v);
      total++;
      if ({out_valid, um} !== {v, ref_m(fwd(x))}) begin
        bad++;
        $display("FAIL toggle cyc%0d byte %02h: got valid=%b m=%b want valid=%b m=%b",
                 i, x, out_valid, um, v, ref_m(fwd(x)));
      end
    end
  endtask

  task automatic test_midstream_reset();
    for (int i = 0; i < 3; i++) step(fwd(8'(8'hA0 + i)), 1'b1);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({out_valid, raw} !== 9'h000) begin
      bad++;
      $display("FAIL midreset_async: got valid=%b m=%h want valid=0 m=00", out_valid, raw);
    end
    #4 rst = 1'b0;
    step(fwd(8'hC7), 1'b1);
    total++;
    if ({out_valid, um} !== {1'b1, ref_m(fwd(8'hC7))}) begin
      bad++;
      $display("FAIL midreset_recover: got valid=%b m=%b want valid=1 m=%b",
               out_valid, um, ref_m(fwd(8'hC7)));
    end
  endtask

  initial begin
    in_valid = 1'b0;
    rnd = '0;
    {i0, t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15, t16, t17} = '0;
    {t19, t20, t22, t23, t24, t25, t26, t27} = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_valid_toggle();
    test_midstream_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
